// File: rtl/mo_line_buffer.sv
// Double-banked motion-object line buffer: write one bank, read-and-erase the other, swap at line start; optional MO_PRIORITY_EN (first-written pixel wins).
// Latency: pix_out is registered, one ce5 tick after the read address; reset sweep takes 2^AW clk with busy high.
// Backpressure: none; the buffer accepts a pixel slot on every ce5 tick and ignores all run inputs while busy.
module mo_line_buffer #(
  parameter int AW = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce5,
  input  logic          line_start,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_pix,
  output logic [PW-1:0] pix_out,
  output logic          busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] sweep_cnt;
  logic          sel;
  logic          wr_do;
  logic [PW-1:0] rd_dat;

  // Bank 0 is only ever addressed by counter 1 and bank 1 by counter 2;
  // sel just decides which of the two is being written and which is read.
  logic [PW-1:0] bank0 [0:DEPTH-1];
  logic [PW-1:0] bank1 [0:DEPTH-1];

`ifdef MO_PRIORITY_EN
  logic [PW-1:0] wr_cur;
  assign wr_cur = sel ? bank1[addr2] : bank0[addr1];
`endif

  assign rd_dat = sel ? bank0[addr1] : bank1[addr2];

  // Qualify a sprite write: transparent pixels never land, and with
  // priority enabled an occupied entry keeps the earlier sprite.
  always_comb begin
    wr_do = ce5 && wr_en && (wr_pix != '0);
`ifdef MO_PRIORITY_EN
    wr_do = wr_do && (wr_cur == '0);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  // Next state: leave CLEAR once the last entry has been swept.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (&sweep_cnt) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // Sweep counter, bank select and the registered output pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_cnt <= '0;
      sel       <= 1'b0;
      pix_out   <= '0;
    end else if (state == CLEAR) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      pix_out   <= '0;
    end else if (ce5) begin
      pix_out <= rd_dat;
      if (line_start) sel <= ~sel;
    end
  end

  // Bank storage: sweep clear, then per-tick write of one bank and
  // read-first erase of the other (they never share a bank, so no collision).
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        bank0[sweep_cnt] <= '0;
        bank1[sweep_cnt] <= '0;
      end else if (ce5) begin
        if (sel) begin
          bank0[addr1] <= '0;
          if (wr_do) bank1[addr2] <= wr_pix;
        end else begin
          bank1[addr2] <= '0;
          if (wr_do) bank0[addr1] <= wr_pix;
        end
      end
    end
  end

endmodule

// File: tb/tb_mo_line_buffer.sv
// Self-checking bench for mo_line_buffer against a per-tick behavioural model.
// Latency: checks pix_out 1 time unit after each clk edge.
// Backpressure: none; stimulus is one pixel slot per ce5 tick.
module tb_mo_line_buffer;

  localparam int AW    = 8;
  localparam int PW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce5 = 1'b0;
  logic          line_start = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [AW-1:0] addr2 = '0;
  logic          wr_en = 1'b0;
  logic [PW-1:0] wr_pix = '0;
  logic [PW-1:0] pix_out;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: two line stores, the bank being written, last output.
  logic [PW-1:0] mb [2][DEPTH];
  bit            msel;
  logic [PW-1:0] mpix;

  mo_line_buffer #(.AW(AW), .PW(PW)) dut (
    .clk(clk), .reset(reset), .ce5(ce5), .line_start(line_start),
    .addr1(addr1), .addr2(addr2), .wr_en(wr_en), .wr_pix(wr_pix),
    .pix_out(pix_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // One clk of run-mode stimulus; the model advances only on a ce5 tick.
  task automatic tick(input bit ce, input bit ls, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input bit we, input logic [PW-1:0] wp);
    int wb, rb;
    logic [AW-1:0] wa, ra;
    ce5 = ce; line_start = ls; addr1 = a1; addr2 = a2; wr_en = we; wr_pix = wp;
    if (ce) begin
      wb = msel ? 1 : 0;
      rb = 1 - wb;
      // Each line store is tied to its own counter.
      wa = (wb == 0) ? a1 : a2;
      ra = (rb == 0) ? a1 : a2;
      mpix = mb[rb][ra];
      mb[rb][ra] = '0;
      if (we && wp != 0) begin
`ifdef MO_PRIORITY_EN
        if (mb[wb][wa] == 0) mb[wb][wa] = wp;
`else
        mb[wb][wa] = wp;
`endif
      end
      if (ls) msel = !msel;
    end
    @(posedge clk); #1;
  endtask

  task automatic to_sel0();
    if (msel) tick(1, 1, '0, '0, 0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ce5 = 1'b1; line_start = 1'b1; wr_en = 1'b1; wr_pix = 4'hF;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) mb[b][i] = '0;
    msel = 1'b0;
    mpix = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy busy=%b expected=1", busy);
    else n_pass++;
    n_checks++;
    if (pix_out !== '0) $display("FAIL reset_pix pix_out=%0d expected=0", pix_out);
    else n_pass++;
  endtask

  // Counts busy cycles while throwing junk at every run input.
  task automatic wait_sweep(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      ce5 = 1'($urandom_range(0, 1)); line_start = 1'($urandom_range(0, 1));
      wr_en = 1'b1; wr_pix = PW'($urandom_range(1, 15));
      addr1 = AW'($urandom); addr2 = AW'($urandom);
      @(posedge clk); #1;
      n++;
      n_checks++;
      if (pix_out !== '0) $display("FAIL %s_sweep_pix cycle=%0d pix_out=%0d expected=0", tag, n, pix_out);
      else n_pass++;
    end
    n_checks++;
    if (n != DEPTH) $display("FAIL %s_busy_len busy_cycles=%0d expected=%0d", tag, n, DEPTH);
    else n_pass++;
    ce5 = 1'b0; line_start = 1'b0; wr_en = 1'b0; wr_pix = '0;
  endtask

  // Reads every entry of both banks; all must be zero.
  task automatic test_all_zero(input string tag);
    int bad = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < DEPTH; i++) begin
        tick(1, i == DEPTH - 1, AW'(i), AW'(i), 0, '0);
        n_checks++;
        if (pix_out !== '0) begin
          bad++;
          if (bad < 5) $display("FAIL %s_zero pass=%0d addr=%0h pix_out=%0d expected=0", tag, p, i, pix_out);
        end else n_pass++;
      end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    do_reset();
    wait_sweep("reset");
    test_all_zero("reset");
  endtask

  task automatic test_basic_line();
    logic [PW-1:0] exp;
    to_sel0();
    tick(1, 0, 8'h40, 8'h00, 1, 4'd5);
    tick(1, 1, 8'h41, 8'h01, 0, '0);
    for (int a = 8'h06; a <= 8'h50; a++) begin
      tick(1, 0, AW'(a), 8'h02, 0, '0);
      exp = (a == 8'h40) ? 4'd5 : 4'd0;
      n_checks++;
      if (pix_out !== exp) $display("FAIL basic_read addr1=%0h pix_out=%0d expected=%0d", a, pix_out, exp);
      else n_pass++;
    end
    tick(1, 1, 8'h00, 8'h00, 0, '0);
    tick(1, 1, 8'h00, 8'h00, 0, '0);
    tick(1, 0, 8'h40, 8'h00, 0, '0);
    n_checks++;
    if (pix_out !== '0) $display("FAIL basic_erased pix_out=%0d expected=0", pix_out);
    else n_pass++;
  endtask

  task automatic test_transparency();
    to_sel0();
    tick(1, 0, 8'h10, 8'h00, 1, 4'd3);
    tick(1, 0, 8'h10, 8'h00, 1, 4'd0);
    tick(1, 1, 8'h11, 8'h00, 0, '0);
    tick(1, 0, 8'h10, 8'h00, 0, '0);
    n_checks++;
    if (pix_out !== 4'd3) $display("FAIL transparency pix_out=%0d expected=3", pix_out);
    else n_pass++;
  endtask

  task automatic test_overlap();
    logic [PW-1:0] exp;
`ifdef MO_PRIORITY_EN
    exp = 4'd7;
`else
    exp = 4'd2;
`endif
    to_sel0();
    tick(1, 0, 8'h20, 8'h00, 1, 4'd7);
    tick(1, 0, 8'h20, 8'h00, 1, 4'd2);
    tick(1, 1, 8'h21, 8'h00, 0, '0);
    tick(1, 0, 8'h20, 8'h00, 0, '0);
    n_checks++;
    if (pix_out !== exp) $display("FAIL overlap pix_out=%0d expected=%0d", pix_out, exp);
    else n_pass++;
  endtask

  task automatic test_swap_edge();
    to_sel0();
    tick(1, 1, 8'h30, 8'h31, 1, 4'd9);
    tick(1, 0, 8'h32, 8'h33, 1, 4'hA);
    // A frozen clk with junk inputs must change nothing.
    tick(0, 1, 8'h30, 8'h33, 1, 4'h1);
    n_checks++;
    if (pix_out !== mpix) $display("FAIL swap_frozen pix_out=%0d expected=%0d", pix_out, mpix);
    else n_pass++;
    tick(1, 1, 8'h00, 8'h00, 0, '0);
    tick(1, 1, 8'h00, 8'h33, 0, '0);
    n_checks++;
    if (pix_out !== 4'hA) $display("FAIL swap_bank1 pix_out=%0d expected=10", pix_out);
    else n_pass++;
    tick(1, 0, 8'h30, 8'h00, 0, '0);
    n_checks++;
    if (pix_out !== 4'd9) $display("FAIL swap_bank0 pix_out=%0d expected=9", pix_out);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0,
           AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), PW'($urandom_range(0, 15)));
      n_checks++;
      if (pix_out !== mpix) $display("FAIL random t=%0d pix_out=%0d expected=%0d", t, pix_out, mpix);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    to_sel0();
    tick(1, 1, 8'h05, 8'h00, 1, 4'hF);
    tick(1, 0, 8'h00, 8'h06, 1, 4'hE);
    do_reset();
    wait_sweep("midline");
    test_all_zero("midline");
  endtask

  initial begin
    msel = 1'b0;
    mpix = '0;
    test_reset();
    test_basic_line();
    test_transparency();
    test_overlap();
    test_swap_edge();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
